// File: rtl/term_pkg.sv
// term_pkg -- shared definitions for the terminal command arbiter.
//   state_t     : arbiter FSM states
//   CMD_W_DEF   : default command width
//   TIMEOUT_DEF : default ISSUE cycle budget before abort
//   SRC_HOST / SRC_KBD : encoding of dec_src and of the round-robin pointer
//   src_onehot  : maps a source code to its bit in the {kbd, host} request vector
package term_pkg;

  localparam int CMD_W_DEF   = 8;
  localparam int TIMEOUT_DEF = 12;

  localparam logic SRC_HOST = 1'b0;
  localparam logic SRC_KBD  = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DONE  = 2'd2,
    ST_ABORT = 2'd3
  } state_t;

  // Request vectors are ordered {kbd, host}, so the source code doubles as
  // the bit index.
  function automatic logic [1:0] src_onehot(input logic src);
    return (src == SRC_KBD) ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/term_rr_pick.sv
// term_rr_pick -- two-way round-robin pick for the terminal arbiter.
//   req  : {kbd, host} raw request levels
//   ptr  : source favoured when both eligible requesters are active
//   mask : {kbd, host} requesters excluded from this pick
//   gnt  : at least one eligible request
//   src  : chosen source (SRC_HOST / SRC_KBD); only meaningful with gnt
// Purely combinational; the caller registers the outcome.
module term_rr_pick
  import term_pkg::*;
(
  input  logic [1:0] req,
  input  logic       ptr,
  input  logic [1:0] mask,
  output logic       gnt,
  output logic       src
);

  logic [1:0] elig;

  always_comb begin
    elig = req & ~mask;
    gnt  = |elig;
    // Contention goes to the pointer; otherwise the lone eligible requester.
    if (&elig) src = ptr;
    else       src = elig[1] ? SRC_KBD : SRC_HOST;
  end

endmodule

// File: rtl/term_arbiter.sv
// term_arbiter -- shares one terminal decoder between the host and the
// keyboard. One command is in flight at a time.
//   clk, rst_n            : clock (rising edge), async active-low reset
//   host_req / host_cmd   : host request level and command (sampled at grant)
//   host_ack              : one-cycle completion pulse to the host
//   kbd_req / kbd_cmd     : keyboard request level and command
//   kbd_ack               : one-cycle completion pulse to the keyboard
//   dec_valid/cmd/src     : command presented to the decoder (held in ISSUE)
//   dec_ready             : decoder accepts the presented command
//   timeout_err           : one-cycle pulse when a command is abandoned
//   busy                  : high in every state except IDLE
// Flow: IDLE -> ISSUE -> DONE (accepted) or ABORT (timed out) -> IDLE.
// Every output is a register, so dec_valid follows a grant by one cycle and
// acks/timeout_err follow the ISSUE decision by one cycle.
module term_arbiter
  import term_pkg::*;
#(
  parameter int CMD_W   = CMD_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             host_req,
  input  logic [CMD_W-1:0] host_cmd,
  output logic             host_ack,
  input  logic             kbd_req,
  input  logic [CMD_W-1:0] kbd_cmd,
  output logic             kbd_ack,
  output logic             dec_valid,
  output logic [CMD_W-1:0] dec_cmd,
  output logic             dec_src,
  input  logic             dec_ready,
  output logic             timeout_err,
  output logic             busy
);

  // Timer only has to reach TIMEOUT-1, so clog2(TIMEOUT) bits suffice and it
  // stops there rather than wrapping.
  localparam int             TW    = $clog2(TIMEOUT);
  localparam logic [TW-1:0]  TLAST = TW'(TIMEOUT - 1);

  state_t        state;
  logic          ptr;
  logic [1:0]    mask;
  logic [TW-1:0] timer;

  logic          pick_gnt;
  logic          pick_src;

  term_rr_pick u_pick (
    .req  ({kbd_req, host_req}),
    .ptr  (ptr),
    .mask (mask),
    .gnt  (pick_gnt),
    .src  (pick_src)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      ptr         <= SRC_HOST;
      mask        <= 2'b00;
      timer       <= '0;
      dec_valid   <= 1'b0;
      dec_cmd     <= '0;
      dec_src     <= SRC_HOST;
      host_ack    <= 1'b0;
      kbd_ack     <= 1'b0;
      timeout_err <= 1'b0;
      busy        <= 1'b0;
    end else begin
      // Pulses default low; they are raised for exactly one cycle below.
      host_ack    <= 1'b0;
      kbd_ack     <= 1'b0;
      timeout_err <= 1'b0;

      case (state)
        ST_IDLE: begin
          // The post-completion mask only covers the first IDLE cycle.
          mask <= 2'b00;
          if (pick_gnt) begin
            state     <= ST_ISSUE;
            dec_valid <= 1'b1;
            busy      <= 1'b1;
            dec_src   <= pick_src;
            dec_cmd   <= (pick_src == SRC_KBD) ? kbd_cmd : host_cmd;
            timer     <= '0;
          end
        end

        ST_ISSUE: begin
          // Acceptance takes priority over the terminal count.
          if (dec_ready) begin
            state     <= ST_DONE;
            dec_valid <= 1'b0;
            host_ack  <= (dec_src == SRC_HOST);
            kbd_ack   <= (dec_src == SRC_KBD);
          end else if (timer == TLAST) begin
            state       <= ST_ABORT;
            dec_valid   <= 1'b0;
            timeout_err <= 1'b1;
          end else begin
            timer <= timer + TW'(1);
          end
        end

        ST_DONE, ST_ABORT: begin
          // Hand the next contention to the other side and keep the
          // just-served requester out of the next arbitration.
          state <= ST_IDLE;
          busy  <= 1'b0;
          ptr   <= ~dec_src;
          mask  <= src_onehot(dec_src);
        end

        default: begin
          state     <= ST_IDLE;
          dec_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule
